// File: rtl/mt_pkg.sv
// Shared types and default sizing for the barrel-processor thread scheduler.
package mt_pkg;

  localparam int DEFAULT_NUM_THREADS  = 8;
  localparam int DEFAULT_PIPE_DEPTH   = 4;
  localparam int DEFAULT_BITS_THREADS = $clog2(DEFAULT_NUM_THREADS);

  typedef logic [DEFAULT_BITS_THREADS-1:0] tid_t;

  typedef struct packed {
    logic valid;
    tid_t tid;
  } sched_slot_t;

endpackage

// File: rtl/mt_rr_pick.sv
// Round-robin picker: rotate the request vector so the slot after 'last' is bit 0,
// take the lowest set bit, then rotate the index back.
module mt_rr_pick #(
  parameter  int NUM_THREADS  = mt_pkg::DEFAULT_NUM_THREADS,
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic [NUM_THREADS-1:0]  req,
  input  logic [BITS_THREADS-1:0] last,
  output logic                    any,
  output logic [BITS_THREADS-1:0] sel
);

  logic [2*NUM_THREADS-1:0] w_double;
  logic [NUM_THREADS-1:0]   w_rot;
  logic [BITS_THREADS:0]    w_shift;
  logic [BITS_THREADS-1:0]  w_idx;

  assign w_shift  = {1'b0, last} + (BITS_THREADS+1)'(1);
  assign w_double = {req, req};
  assign w_rot    = w_double[w_shift +: NUM_THREADS];

  // NOTE: every variable written in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    w_idx = '0;
    for (int j = NUM_THREADS - 1; j >= 0; j--) begin
      if (w_rot[j]) w_idx = BITS_THREADS'(j);
    end
  end

  assign any = |req;
  // Thread count is a power of two, so wrapping is plain truncation.
  assign sel = w_idx + w_shift[BITS_THREADS-1:0];

endmodule

// File: rtl/mt_thread_sched.sv
// Barrel-processor thread scheduler: round-robin issue of runnable threads plus a
// shadow pipeline that carries each issued tid to its writeback slot.
module mt_thread_sched
  import mt_pkg::*;
#(
  parameter  int NUM_THREADS  = DEFAULT_NUM_THREADS,
  parameter  int PIPE_DEPTH   = DEFAULT_PIPE_DEPTH,
  localparam int BITS_THREADS = $clog2(NUM_THREADS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_THREADS-1:0]  thread_enable,
  input  logic                    stall_valid,
  input  logic [BITS_THREADS-1:0] stall_tid,
  input  logic                    wake_valid,
  input  logic [BITS_THREADS-1:0] wake_tid,
  output logic                    issue_valid,
  output logic [BITS_THREADS-1:0] issue_tid,
  output logic                    wb_valid,
  output logic [BITS_THREADS-1:0] wb_tid,
  output logic [NUM_THREADS-1:0]  blocked
);

  typedef struct packed {
    logic                    valid;
    logic [BITS_THREADS-1:0] tid;
  } slot_t;

  logic                    r_issue_valid;
  logic [BITS_THREADS-1:0] r_issue_tid;
  logic [BITS_THREADS-1:0] r_last;
  logic [NUM_THREADS-1:0]  r_blocked;
  slot_t                   r_sr [1:PIPE_DEPTH];

  logic [NUM_THREADS-1:0]  w_inflight;
  logic [NUM_THREADS-1:0]  w_elig;
  logic [NUM_THREADS-1:0]  w_blocked_next;
  logic                    w_any;
  logic [BITS_THREADS-1:0] w_sel;

  // The writeback slot does not hold a thread back: its register-file write lands
  // in the same cycle the thread's next issue is chosen, ahead of that issue's read.
  always_comb begin
    w_inflight = '0;
    if (r_issue_valid) w_inflight[r_issue_tid] = 1'b1;
    for (int k = 1; k < PIPE_DEPTH; k++) begin
      if (r_sr[k].valid) w_inflight[r_sr[k].tid] = 1'b1;
    end
  end

  assign w_elig = thread_enable & ~r_blocked & ~w_inflight;

  // Wake is applied after stall so it wins when both name the same thread.
  always_comb begin
    w_blocked_next = r_blocked;
    if (stall_valid) w_blocked_next[stall_tid] = 1'b1;
    if (wake_valid)  w_blocked_next[wake_tid]  = 1'b0;
  end

  mt_rr_pick #(
    .NUM_THREADS (NUM_THREADS)
  ) u_pick (
    .req  (w_elig),
    .last (r_last),
    .any  (w_any),
    .sel  (w_sel)
  );

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values and the shift chain moves exactly one stage per clock.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issue_valid <= 1'b0;
      r_issue_tid   <= '0;
      r_last        <= BITS_THREADS'(NUM_THREADS - 1);
      r_blocked     <= '0;
      // NOTE: the shadow pipe is reset, not left to drain, because a stale valid
      // bit would fire a register-file write after reset.
      for (int k = 1; k <= PIPE_DEPTH; k++) begin
        r_sr[k] <= '0;
      end
    end else begin
      r_issue_valid <= w_any;
      if (w_any) begin
        r_issue_tid <= w_sel;
        r_last      <= w_sel;
      end
      r_blocked <= w_blocked_next;
      r_sr[1]   <= '{valid: r_issue_valid, tid: r_issue_tid};
      for (int k = 2; k <= PIPE_DEPTH; k++) begin
        r_sr[k] <= r_sr[k-1];
      end
    end
  end

  assign issue_valid = r_issue_valid;
  assign issue_tid   = r_issue_tid;
  assign wb_valid    = r_sr[PIPE_DEPTH].valid;
  assign wb_tid      = r_sr[PIPE_DEPTH].tid;
  assign blocked     = r_blocked;

endmodule

// File: tb/tb_mt_thread_sched.sv
// Directed bench for mt_thread_sched (8 threads, depth 4); outputs sampled on negedge.
module tb_mt_thread_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] thread_enable;
  logic       stall_valid;
  logic [2:0] stall_tid;
  logic       wake_valid;
  logic [2:0] wake_tid;
  logic       issue_valid;
  logic [2:0] issue_tid;
  logic       wb_valid;
  logic [2:0] wb_tid;
  logic [7:0] blocked;

  int errors = 0;
  int checks = 0;

  mt_thread_sched dut (
    .clk           (clk),
    .rst           (rst),
    .thread_enable (thread_enable),
    .stall_valid   (stall_valid),
    .stall_tid     (stall_tid),
    .wake_valid    (wake_valid),
    .wake_tid      (wake_tid),
    .issue_valid   (issue_valid),
    .issue_tid     (issue_tid),
    .wb_valid      (wb_valid),
    .wb_tid        (wb_tid),
    .blocked       (blocked)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Holds reset for one posedge with the given enable mask, releases it on the next negedge.
  task automatic do_reset(input logic [7:0] en);
    thread_enable = en;
    stall_valid   = 1'b0;
    stall_tid     = '0;
    wake_valid    = 1'b0;
    wake_tid      = '0;
    rst           = 1'b1;
    tick();
    rst           = 1'b0;
  endtask

  task automatic test_reset();
    thread_enable = 8'hFF;
    stall_valid   = 1'b0;
    stall_tid     = '0;
    wake_valid    = 1'b0;
    wake_tid      = '0;
    rst           = 1'b1;
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset issue_valid: got %b want 0", issue_valid); end
    checks++; if (issue_tid !== 3'd0) begin errors++; $display("FAIL reset issue_tid: got %0d want 0", issue_tid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_tid !== 3'd0) begin errors++; $display("FAIL reset wb_tid: got %0d want 0", wb_tid); end
    checks++; if (blocked !== 8'h00) begin errors++; $display("FAIL reset blocked: got %h want 00", blocked); end
    rst = 1'b0;
  endtask

  task automatic test_all_enabled();
    logic [2:0] exp_tid;
    logic       exp_wb;
    do_reset(8'hFF);
    for (int i = 0; i < 9; i++) begin
      tick();
      exp_tid = 3'(i % 8);
      exp_wb  = (i >= 4);
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL all_en issue_valid[%0d]: got %b want 1", i, issue_valid); end
      checks++; if (issue_tid !== exp_tid) begin errors++; $display("FAIL all_en issue_tid[%0d]: got %0d want %0d", i, issue_tid, exp_tid); end
      checks++; if (wb_valid !== exp_wb) begin errors++; $display("FAIL all_en wb_valid[%0d]: got %b want %b", i, wb_valid, exp_wb); end
      if (exp_wb) begin
        exp_tid = 3'((i - 4) % 8);
        checks++; if (wb_tid !== exp_tid) begin errors++; $display("FAIL all_en wb_tid[%0d]: got %0d want %0d", i, wb_tid, exp_tid); end
      end
    end
  endtask

  task automatic test_lone_thread();
    logic exp_iv;
    logic exp_wb;
    do_reset(8'h08);
    for (int i = 0; i < 11; i++) begin
      tick();
      exp_iv = (i % 5 == 0);
      exp_wb = (i % 5 == 4);
      checks++; if (issue_valid !== exp_iv) begin errors++; $display("FAIL lone issue_valid[%0d]: got %b want %b", i, issue_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (issue_tid !== 3'd3) begin errors++; $display("FAIL lone issue_tid[%0d]: got %0d want 3", i, issue_tid); end
      end
      checks++; if (wb_valid !== exp_wb) begin errors++; $display("FAIL lone wb_valid[%0d]: got %b want %b", i, wb_valid, exp_wb); end
      if (exp_wb) begin
        checks++; if (wb_tid !== 3'd3) begin errors++; $display("FAIL lone wb_tid[%0d]: got %0d want 3", i, wb_tid); end
      end
    end
  endtask

  task automatic test_four_threads();
    logic       exp_iv;
    logic       exp_wb;
    logic [2:0] exp_tid;
    do_reset(8'h0F);
    for (int i = 0; i < 12; i++) begin
      tick();
      exp_iv  = (i % 5 != 4);
      exp_tid = 3'(i % 5);
      exp_wb  = (i >= 4) && ((i - 4) % 5 != 4);
      checks++; if (issue_valid !== exp_iv) begin errors++; $display("FAIL four issue_valid[%0d]: got %b want %b", i, issue_valid, exp_iv); end
      if (exp_iv) begin
        checks++; if (issue_tid !== exp_tid) begin errors++; $display("FAIL four issue_tid[%0d]: got %0d want %0d", i, issue_tid, exp_tid); end
      end
      checks++; if (wb_valid !== exp_wb) begin errors++; $display("FAIL four wb_valid[%0d]: got %b want %b", i, wb_valid, exp_wb); end
      if (exp_wb) begin
        exp_tid = 3'((i - 4) % 5);
        checks++; if (wb_tid !== exp_tid) begin errors++; $display("FAIL four wb_tid[%0d]: got %0d want %0d", i, wb_tid, exp_tid); end
      end
    end
  endtask

  task automatic test_stall_wake();
    int         exp_seq [18] = '{0, 1, 3, 4, 5, 6, 7, 0, 1, 3, 4, 5, 6, 7, 0, 1, 2, 3};
    logic [2:0] exp_tid;
    logic [7:0] exp_blk;
    do_reset(8'hFF);
    for (int i = 0; i < 18; i++) begin
      tick();
      exp_tid = 3'(exp_seq[i]);
      exp_blk = (i >= 1 && i <= 8) ? 8'h04 : 8'h00;
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL stall issue_valid[%0d]: got %b want 1", i, issue_valid); end
      checks++; if (issue_tid !== exp_tid) begin errors++; $display("FAIL stall issue_tid[%0d]: got %0d want %0d", i, issue_tid, exp_tid); end
      checks++; if (blocked !== exp_blk) begin errors++; $display("FAIL stall blocked[%0d]: got %h want %h", i, blocked, exp_blk); end
      stall_valid = (i == 0);
      stall_tid   = 3'd2;
      wake_valid  = (i == 8);
      wake_tid    = 3'd2;
    end
    stall_valid = 1'b0;
    wake_valid  = 1'b0;
  endtask

  task automatic test_stall_wake_same_cycle();
    logic [7:0] exp_blk [5] = '{8'h00, 8'h00, 8'h02, 8'h12, 8'h02};
    logic       st_v    [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [2:0] st_t    [5] = '{3'd5, 3'd1, 3'd4, 3'd4, 3'd0};
    logic       wk_v    [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [2:0] wk_t    [5] = '{3'd5, 3'd4, 3'd0, 3'd4, 3'd0};
    do_reset(8'hFF);
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (blocked !== exp_blk[i]) begin errors++; $display("FAIL same_cycle blocked[%0d]: got %h want %h", i, blocked, exp_blk[i]); end
      stall_valid = st_v[i];
      stall_tid   = st_t[i];
      wake_valid  = wk_v[i];
      wake_tid    = wk_t[i];
    end
  endtask

  task automatic test_enable_drop();
    logic       exp_iv  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [2:0] exp_tid [8] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd5};
    logic       exp_wb  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [2:0] exp_wbt [8] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd0, 3'd0};
    logic [7:0] exp_blk;
    do_reset(8'hFF);
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_blk = (i >= 1) ? 8'h08 : 8'h00;
      checks++; if (issue_valid !== exp_iv[i]) begin errors++; $display("FAIL en_drop issue_valid[%0d]: got %b want %b", i, issue_valid, exp_iv[i]); end
      if (exp_iv[i]) begin
        checks++; if (issue_tid !== exp_tid[i]) begin errors++; $display("FAIL en_drop issue_tid[%0d]: got %0d want %0d", i, issue_tid, exp_tid[i]); end
      end
      checks++; if (wb_valid !== exp_wb[i]) begin errors++; $display("FAIL en_drop wb_valid[%0d]: got %b want %b", i, wb_valid, exp_wb[i]); end
      if (exp_wb[i]) begin
        checks++; if (wb_tid !== exp_wbt[i]) begin errors++; $display("FAIL en_drop wb_tid[%0d]: got %0d want %0d", i, wb_tid, exp_wbt[i]); end
      end
      checks++; if (blocked !== exp_blk) begin errors++; $display("FAIL en_drop blocked[%0d]: got %h want %h", i, blocked, exp_blk); end
      stall_valid = (i == 0);
      stall_tid   = 3'd3;
      if (i == 1) thread_enable = 8'h00;
      if (i == 6) thread_enable = 8'h20;
    end
    stall_valid = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic exp_wb;
    do_reset(8'hFF);
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (issue_tid !== 3'(i)) begin errors++; $display("FAIL mid_rst pre issue_tid[%0d]: got %0d want %0d", i, issue_tid, i); end
      stall_valid = (i == 1);
      stall_tid   = 3'd6;
    end
    stall_valid = 1'b0;
    rst = 1'b1;
    tick();
    checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL mid_rst issue_valid: got %b want 0", issue_valid); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_rst wb_valid: got %b want 0", wb_valid); end
    checks++; if (blocked !== 8'h00) begin errors++; $display("FAIL mid_rst blocked: got %h want 00", blocked); end
    rst = 1'b0;
    for (int j = 0; j < 5; j++) begin
      tick();
      exp_wb = (j == 4);
      checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL mid_rst post issue_valid[%0d]: got %b want 1", j, issue_valid); end
      checks++; if (issue_tid !== 3'(j)) begin errors++; $display("FAIL mid_rst post issue_tid[%0d]: got %0d want %0d", j, issue_tid, j); end
      checks++; if (wb_valid !== exp_wb) begin errors++; $display("FAIL mid_rst post wb_valid[%0d]: got %b want %b", j, wb_valid, exp_wb); end
      if (exp_wb) begin
        checks++; if (wb_tid !== 3'd0) begin errors++; $display("FAIL mid_rst post wb_tid[%0d]: got %0d want 0", j, wb_tid); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_enabled();
    test_lone_thread();
    test_four_threads();
    test_stall_wake();
    test_stall_wake_same_cycle();
    test_enable_drop();
    test_reset_midflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
